// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DONE_PASS = 2'd1,
    DONE_FAIL = 2'd2,
    TIMEOUT   = 2'd3
  } dmem_state_t;

  localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;
  localparam logic [31:0] TOHOST_PASS = 32'd1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM with combinational read and per-byte-lane write.
module dmem_byte_ram #(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];

  // Lane-wise write; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we[k]) begin
        mem_r[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: RAM, tohost completion register, watchdog, status flags.
// Define DMEM_BYTE_WRITE_EN to allow partial (per-lane) RAM writes.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH          = 1024,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] d_mem_addr,
  input  logic [31:0] d_mem_wdata,
  input  logic [3:0]  d_mem_wen,
  output logic [31:0] d_mem_rdata,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] fail_code,
  output logic        addr_err,
  output logic [15:0] wr_count
);

  localparam int          AW           = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES    = 32'(4 * DEPTH);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
  localparam bit          WDOG_EN      = (TIMEOUT_CYCLES != 32'd0);

  dmem_state_t state_r;
  dmem_state_t state_nxt_s;
  logic [31:0] tohost_r;
  logic [31:0] cyc_r;
  logic        done_r;
  logic        pass_r;
  logic        timeout_r;
  logic [30:0] fail_code_r;
  logic        addr_err_r;
  logic [15:0] wr_count_r;

  logic        ram_hit_s;
  logic        tohost_hit_s;
  logic        oor_s;
  logic        wr_req_s;
  logic        misalign_s;
  logic        lanes_ok_s;
  logic [3:0]  ram_we_s;
  logic        tohost_wr_s;
  logic        err_s;
  logic        expire_s;
  logic [31:0] ram_rdata_s;

  dmem_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (d_mem_addr[AW+1:2]),
    .wdata (d_mem_wdata),
    .raddr (d_mem_addr[AW+1:2]),
    .rdata (ram_rdata_s)
  );

  // Address decode, write qualification and read mux.
  always_comb begin
    ram_hit_s    = (d_mem_addr < RAM_BYTES);
    tohost_hit_s = (d_mem_addr == TOHOST_ADDR);
    oor_s        = !ram_hit_s && !tohost_hit_s;
    wr_req_s     = rst_n && (state_r == RUN) && (d_mem_wen != 4'b0000);
    misalign_s   = (d_mem_addr[1:0] != 2'b00);
`ifdef DMEM_BYTE_WRITE_EN
    lanes_ok_s   = 1'b1;
`else
    lanes_ok_s   = (d_mem_wen == 4'b1111);
`endif
    if (wr_req_s && ram_hit_s && !misalign_s && lanes_ok_s) begin
      ram_we_s = d_mem_wen;
    end else begin
      ram_we_s = 4'b0000;
    end
    tohost_wr_s  = wr_req_s && tohost_hit_s && !misalign_s && (d_mem_wen == 4'b1111);
    // Out-of-range reads flag too, even after the program has finished.
    err_s        = oor_s ||
                   (wr_req_s && (misalign_s ||
                                 (ram_hit_s && !lanes_ok_s) ||
                                 (tohost_hit_s && (d_mem_wen != 4'b1111))));
    expire_s     = WDOG_EN && (cyc_r == TIMEOUT_LAST);

    if (ram_hit_s) begin
      d_mem_rdata = ram_rdata_s;
    end else if (tohost_hit_s) begin
      d_mem_rdata = tohost_r;
    end else begin
      d_mem_rdata = ERR_DATA;
    end
  end

  // Next-state logic; an accepted tohost write beats a same-cycle expiry.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (tohost_wr_s) begin
          state_nxt_s = (d_mem_wdata == TOHOST_PASS) ? DONE_PASS : DONE_FAIL;
        end else if (expire_s) begin
          state_nxt_s = TIMEOUT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE_PASS, DONE_FAIL, TIMEOUT: state_nxt_s = state_r;
      default:                       state_nxt_s = RUN;
    endcase
  end

  // State register with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= RUN;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      done_r    <= (state_nxt_s != RUN);
      pass_r    <= (state_nxt_s == DONE_PASS);
      timeout_r <= (state_nxt_s == TIMEOUT);
    end
  end

  // Tohost latch, watchdog, sticky error flag and write counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tohost_r    <= 32'd0;
      cyc_r       <= 32'd0;
      fail_code_r <= 31'd0;
      addr_err_r  <= 1'b0;
      wr_count_r  <= 16'd0;
    end else begin
      if (tohost_wr_s) begin
        tohost_r <= d_mem_wdata;
        if (d_mem_wdata != TOHOST_PASS) begin
          fail_code_r <= d_mem_wdata[31:1];
        end else begin
          fail_code_r <= fail_code_r;
        end
      end else begin
        tohost_r <= tohost_r;
      end
      if (state_r == RUN) begin
        cyc_r <= cyc_r + 32'd1;
      end else begin
        cyc_r <= cyc_r;
      end
      if (err_s) begin
        addr_err_r <= 1'b1;
      end else begin
        addr_err_r <= addr_err_r;
      end
      if (ram_we_s != 4'b0000) begin
        wr_count_r <= sat_inc16(wr_count_r);
      end else begin
        wr_count_r <= wr_count_r;
      end
    end
  end

  assign done      = done_r;
  assign pass      = pass_r;
  assign timeout   = timeout_r;
  assign fail_code = fail_code_r;
  assign addr_err  = addr_err_r;
  assign wr_count  = wr_count_r;

endmodule
